exec_sequencer: RTL



---
 rtl/exec_sequencer_if.sv | 15 +
 rtl/exec_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: instruction/data memory handshake and core instruction bundle
interface exec_sequencer_if #(parameter int PC_WIDTH = 8) ();
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [15:0]         imem_rdata;
  logic [15:0]         instr;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;
  modport master (output imem_req, imem_addr, instr, dmem_req, dmem_we,
                  input  imem_ack, imem_rdata, dmem_ack);
  modport slave  (input  imem_req, imem_addr, instr, dmem_req, dmem_we,
                  output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute controller for the 16-bit core; SEQ_SINGLE_STEP_EN adds step_mode/step and a PAUSE state
module exec_sequencer #(
  parameter int         PC_WIDTH    = 8,
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step_mode,
  input  logic                step,
`endif
  exec_sequencer_if.master    bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         retired,
  output logic                busy,
  output logic                halted
);
`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT, PAUSE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
`endif
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ret_q, ret_d, ir_q, ir_d;
  logic [3:0]          fetch_op;
  logic                retire;
  assign fetch_op = bus.imem_rdata[15:12];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      IDLE, HALT: if (start) begin
        state_d = FETCH;
        pc_d    = '0;
        ret_d   = '0;
      end
      FETCH: if (bus.imem_ack) begin
        ir_d    = bus.imem_rdata;
        state_d = (fetch_op == HALT_OPCODE) ? HALT :
                  (fetch_op == 4'b0111 || fetch_op == 4'b1000) ? MEM : EXEC;
      end
      EXEC: retire = 1'b1;
      MEM:  retire = bus.dmem_ack;
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE: if (step || !step_mode) state_d = FETCH;
`endif
      default: state_d = IDLE;
    endcase
    if (retire) begin
      pc_d  = pc_q + 1'b1;
      ret_d = &ret_q ? ret_q : ret_q + 16'd1;
`ifdef SEQ_SINGLE_STEP_EN
      state_d = step_mode ? PAUSE : FETCH;
`else
      state_d = FETCH;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      ir_q    <= ir_d;
    end
  end
  assign bus.imem_req  = state_q == FETCH;
  assign bus.imem_addr = pc_q;
  assign bus.instr     = (state_q == EXEC || state_q == MEM) ? ir_q : 16'h0000;
  assign bus.dmem_req  = state_q == MEM;
  assign bus.dmem_we   = state_q == MEM && ir_q[15:12] == 4'b1000;
  assign pc            = pc_q;
  assign retired       = ret_q;
`ifdef SEQ_SINGLE_STEP_EN
  assign busy          = state_q == FETCH || state_q == EXEC || state_q == MEM || state_q == PAUSE;
`else
  assign busy          = state_q == FETCH || state_q == EXEC || state_q == MEM;
`endif
  assign halted        = state_q == HALT;
endmodule
